// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory request/ack, decode-side valid/ready and redirect/fault.
// The master modport is the fetch unit; the slave modport is memory plus the downstream pipeline.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instruction,
    output pc_out,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instruction,
    input  pc_out,
    output redirect_valid,
    output redirect_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: one outstanding memory request, registered instruction, redirect/drop.
// Build option FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets in a FAULT state.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {StIdle, StReq, StHold, StDrop, StFault} state_e;
  localparam state_e StTrap = StFault;
`else
  typedef enum logic [2:0] {StIdle, StReq, StHold, StDrop} state_e;
  localparam state_e StTrap = StReq;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] redir_tgt;
  logic [31:0] launch_pc;
  logic        launch;
  logic        launch_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt  = bus.redirect_pc;
  assign launch_bad = |launch_pc[1:0];
`else
  assign redir_tgt  = bus.redirect_pc & 32'hFFFF_FFFC;
  assign launch_bad = 1'b0;
`endif

  // A launch starts a fresh fetch (or traps): reset exit, accepted word, redirect, drop completion.
  always_comb begin
    launch = 1'b0;
    unique case (state_q)
      StIdle:  launch = 1'b1;
      StReq:   launch = bus.redirect_valid && bus.imem_ack;
      StHold:  launch = bus.redirect_valid || bus.instr_ready;
      StDrop:  launch = bus.imem_ack;
`ifdef FETCH_MISALIGN_TRAP_EN
      StFault: launch = bus.redirect_valid;
`endif
      default: launch = 1'b0;
    endcase
  end

  always_comb begin
    if (bus.redirect_valid) begin
      launch_pc = redir_tgt;
    end else if (state_q == StHold) begin
      launch_pc = pc_q + 32'd4;
    end else begin
      launch_pc = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= NopInstr;
      pc_out_q <= 32'h0000_0000;
    end else if (launch) begin
      pc_q    <= launch_pc;
      valid_q <= 1'b0;
      if (launch_bad) begin
        state_q <= StTrap;
        req_q   <= 1'b0;
      end else begin
        state_q <= StReq;
        req_q   <= 1'b1;
        addr_q  <= launch_pc;
      end
    end else begin
      case (state_q)
        StReq: begin
          if (bus.redirect_valid) begin
            // Memory still owes us a word for addr_q; keep asking and throw it away later.
            pc_q    <= redir_tgt;
            state_q <= StDrop;
          end else if (bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= addr_q;
            valid_q  <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= StHold;
          end
        end
        StDrop: begin
          if (bus.redirect_valid) begin
            pc_q <= redir_tgt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (launch) begin
      fault_q <= launch_bad;
    end
  end

  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instruction = instr_q;
  assign bus.pc_out      = pc_out_q;

  // An issued request keeps its address until the memory answers it.
  req_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    req_q && !bus.imem_ack |=> req_q && $stable(addr_q));

  valid_req_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid_q && req_q));
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: random-latency memory, scoreboard of accepted words.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          last_acc = -1;
  int          wait_cnt = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  bit          busy = 1'b0;
  bit          stray_en = 1'b0;
  bit          tput_chk = 1'b0;
  bit          ack_chk = 1'b0;
  logic [31:0] model_pc = RESET_PC;

  logic        p_req, p_ack, p_valid, p_ready, p_rv;
  logic [31:0] p_addr, p_instr, p_pcout;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0093;
  endfunction

  // Where the next delivered word must come from after a redirect.
  function automatic logic [31:0] land(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of memory behaviour plus downstream/redirect stimulus and model update.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    if (bus.imem_ack) begin
      bus.imem_ack = 1'b0;
      busy         = 1'b0;
    end
    if (rst_n && bus.imem_req && !busy) begin
      busy     = 1'b1;
      wait_cnt = int'($urandom_range(lat_hi, lat_lo));
    end
    if (busy) begin
      if (wait_cnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_fn(bus.imem_addr);
      end else begin
        wait_cnt--;
        bus.imem_rdata = $urandom;
      end
    end else if (stray_en && $urandom_range(7, 0) == 0) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = $urandom;
    end
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (rv) begin
      model_pc = land(rpc);
    end else if (rdy && bus.instr_valid) begin
      exp_q.push_back('{pc: model_pc, instr: mem_fn(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic enter_reset();
    rst_n              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    busy               = 1'b0;
    exp_q.delete();
    model_pc           = RESET_PC;
  endtask

  task automatic check_reset_values();
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instruction", bus.instruction, 32'h0000_0013);
    chk("rst_pc_out", bus.pc_out, 32'h0);
    chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
  endtask

  // Monitor: protocol rules every cycle, scoreboard pop on every accepted instruction.
  initial begin
    exp_t e;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_rv = 1'b0;
    p_addr = '0; p_instr = '0; p_pcout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_rv = 1'b0;
        last_acc = -1;
      end else begin
`ifndef FETCH_MISALIGN_TRAP_EN
        chk("fault_tied_low", 32'(bus.fetch_fault), 32'd0);
`endif
        if (p_req && !p_ack) begin
          chk("req_held", 32'(bus.imem_req), 32'd1);
          chk("addr_held", bus.imem_addr, p_addr);
        end
        if (p_valid && !p_ready && !p_rv) begin
          chk("valid_held", 32'(bus.instr_valid), 32'd1);
          chk("instr_held", bus.instruction, p_instr);
          chk("pc_out_held", bus.pc_out, p_pcout);
        end
        if (p_rv) chk("valid_after_redirect", 32'(bus.instr_valid), 32'd0);
        if (ack_chk && p_req && p_ack && !p_rv) begin
          chk("valid_after_ack", 32'(bus.instr_valid), 32'd1);
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_accept: actual pc_out %h required no instruction",
                     bus.pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("pc_out", bus.pc_out, e.pc);
            chk("instruction", bus.instruction, e.instr);
          end
          if (tput_chk && last_acc >= 0) chk("accept_interval", 32'(cyc - last_acc), 32'd2);
          last_acc = cyc;
        end
        p_req   = bus.imem_req;
        p_ack   = bus.imem_ack;
        p_addr  = bus.imem_addr;
        p_valid = bus.instr_valid;
        p_ready = bus.instr_ready;
        p_rv    = bus.redirect_valid;
        p_instr = bus.instruction;
        p_pcout = bus.pc_out;
      end
    end
  end

  initial begin
    int k;
    bus.imem_rdata = 32'h0;
    enter_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Zero-wait memory, ready held high: back-to-back fetches at 0,4,8,...
    tput_chk = 1'b1;
    ack_chk  = 1'b1;
    lat_lo   = 0;
    lat_hi   = 0;
    repeat (20) cycle(1'b1, 1'b0, 32'h0);
    chk("tput_accepts", 32'(n_acc >= 8), 32'd1);
    tput_chk = 1'b0;

    // Three-cycle memory latency.
    lat_lo = 3;
    lat_hi = 3;
    repeat (16) cycle(1'b1, 1'b0, 32'h0);
    ack_chk = 1'b0;

    // Stall in HOLD, then redirect together with ready: redirect wins.
    lat_lo = 0;
    lat_hi = 2;
    k = 0;
    while (!bus.instr_valid && k < 30) begin
      cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    chk("hold_reached", 32'(bus.instr_valid), 32'd1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Redirect while a request is outstanding; its data must be dropped.
    lat_lo = 3;
    lat_hi = 3;
    k = 0;
    while (!(busy && wait_cnt >= 2) && k < 30) begin
      cycle(1'b1, 1'b0, 32'h0);
      k++;
    end
    chk("request_outstanding", 32'(busy && wait_cnt >= 2), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    repeat (14) cycle(1'b1, 1'b0, 32'h0);

    // pc wraps from the top of the address space to zero.
    lat_lo = 0;
    lat_hi = 1;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (12) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
    cycle(1'b1, 1'b1, 32'h0000_0102);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    chk("fault_set", 32'(bus.fetch_fault), 32'd1);
    chk("fault_no_req", 32'(bus.imem_req), 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0104);
    cycle(1'b1, 1'b0, 32'h0);
    chk("fault_cleared", 32'(bus.fetch_fault), 32'd0);
    chk("fault_exit_addr", bus.imem_addr, 32'h0000_0104);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
`else
    cycle(1'b1, 1'b1, 32'h0000_0102);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
`endif

    // Reset in the middle of a slow request; the stale response must never surface.
    lat_lo = 5;
    lat_hi = 5;
    k = 0;
    while (!(busy && wait_cnt >= 2) && k < 30) begin
      cycle(1'b1, 1'b0, 32'h0);
      k++;
    end
    chk("slow_request_outstanding", 32'(busy && wait_cnt >= 2), 32'd1);
    enter_reset();
    #1;
    check_reset_values();
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    rst_n  = 1'b1;
    lat_lo = 0;
    lat_hi = 2;
    repeat (12) cycle(1'b1, 1'b0, 32'h0);

    // Random traffic: latency, backpressure, redirects and stray acks.
    lat_lo   = 0;
    lat_hi   = 3;
    stray_en = 1'b1;
    repeat (1500) begin
      bit          rdy;
      bit          rv;
      logic [31:0] t;
      rdy = ($urandom_range(9, 0) < 7);
      rv  = ($urandom_range(15, 0) == 0);
      t   = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      t[1:0] = 2'b00;
`endif
      cycle(rdy, rv, t);
    end
    stray_en = 1'b0;
    repeat (4) cycle(1'b0, 1'b0, 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("accepts_seen", 32'(n_acc > 100), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word address of the request, equal to the internal pc.
REQ-006 imem_ack  input  1  memory completion strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr_valid  output  1  instruction register holds a valid word for decode and immediate generation.
REQ-009 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-010 instruction  output  32  registered instruction word.
REQ-011 pc_out  output  32  address of the word in instruction.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  32  redirect target.
REQ-014 fetch_fault  output  1  misaligned-target fault flag, see REQ-030.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, HOLD, DROP, and FAULT (FAULT is reachable only per REQ-030).
REQ-016 IDLE: lasts one cycle after reset release, then REQ.
REQ-017 REQ: imem_req=1 and imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-018 REQ with imem_ack: the block SHALL latch imem_rdata into instruction and pc into pc_out, set instr_valid=1 next cycle, and go to HOLD.
REQ-019 HOLD: instr_valid=1 and instruction and pc_out held stable; imem_req=0.
REQ-020 HOLD with instr_ready=1: pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), instr_valid=0 next cycle, next state REQ.
REQ-021 Minimum throughput SHALL be one instruction per 2 cycles with a zero-wait memory (ack in first REQ cycle).
REQ-022 Redirect priority: redirect_valid=1 in any state SHALL override all other transitions; pc <= redirect_pc; instr_valid=0 next cycle.
REQ-023 Redirect in HOLD or IDLE: next state REQ; a simultaneous instr_ready SHALL be ignored (no pc+4).
REQ-024 Redirect in REQ without imem_ack: next state DROP; imem_req and imem_addr SHALL stay at the old address until ack.
REQ-025 DROP: on imem_ack the data SHALL be discarded, instr_valid SHALL stay 0, and the next state SHALL be REQ with the new pc; a further redirect in DROP SHALL only update pc.
REQ-026 Redirect in REQ coincident with imem_ack: the data SHALL be discarded and the next state SHALL be REQ with redirect_pc.
REQ-027 imem_ack outside REQ or DROP SHALL be ignored.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=32'h0000_0013 (NOP), pc_out=0, fetch_fault=0.
REQ-029 Reset asserted mid-request SHALL abandon the transaction immediately; no response to it SHALL be captured after release.

Configuration
REQ-030 With FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set pc=redirect_pc and enter FAULT (after any DROP completion); in FAULT: fetch_fault=1, imem_req=0, instr_valid=0; only an aligned redirect SHALL leave FAULT (fetch_fault=0 next cycle, then REQ).
REQ-031 Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 2'b00, FAULT SHALL be absent, and fetch_fault SHALL be tied to 0; the port SHALL exist in both builds.

Verification
REQ-032 Reset release, RESET_PC=0, ack same cycle, ready held 1 -> fetches at 0,4,8, one instr_valid pulse per 2 cycles, pc_out matching.
REQ-033 Ack delayed 3 cycles with imem_rdata=32'h00A00093 -> imem_addr stable for 4 cycles; instruction=32'h00A00093 and instr_valid the cycle after ack.
REQ-034 HOLD with ready=0 for 5 cycles, then redirect_pc=32'h100 and ready=1 together -> no pc+4; next request to 32'h100.
REQ-035 Redirect to 32'h200 while a request to 32'h8 is outstanding, ack 2 cycles later -> 32'h8 data discarded, next request to 32'h200.
REQ-036 pc=32'hFFFF_FFFC accepted -> next imem_addr=0.
REQ-037 With the macro defined, redirect_pc=32'h102 -> fetch_fault=1 and no request; then redirect_pc=32'h104 -> fault cleared and request to 32'h104; without the macro, 32'h102 -> request to 32'h100.
